// File: rtl/quant_pipe.sv
// JPEG coefficient quantizer: coefficient times per-position reciprocal, with run-time loadable tables.
// Latency 3 cycles; all stages advance together whenever the output register is empty or being drained.
module quant_pipe #(
    parameter int DATA_WIDTH  = 10,
    parameter int OUT_WIDTH   = DATA_WIDTH,
    parameter int RECIP_WIDTH = 16,
    parameter int NUM_TABLES  = 2,
    parameter int ROUND       = 1,
    localparam int TSW        = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [5:0]              in_addr,
    input  logic [TSW-1:0]          in_tsel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_WIDTH-1:0]    out_data,
    output logic [5:0]              out_addr,
    output logic                    out_eob,
    output logic                    out_sat,
    input  logic                    tbl_we,
    input  logic [TSW-1:0]          tbl_sel,
    input  logic [5:0]              tbl_addr,
    input  logic [RECIP_WIDTH:0]    tbl_wdata
);

    localparam int PW = DATA_WIDTH + RECIP_WIDTH + 2;
    localparam int XW = ((PW + 1) > OUT_WIDTH) ? PW + 1 : OUT_WIDTH + 1;
    localparam logic [RECIP_WIDTH:0] RECIP_ONE = {1'b1, {RECIP_WIDTH{1'b0}}};
    localparam logic [XW-1:0] MAXQ = {{(XW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [XW-1:0] HALF = (ROUND != 0) ? (XW'(1) << (RECIP_WIDTH-1)) : '0;

    logic [RECIP_WIDTH:0]          r_tbl [NUM_TABLES][64];

    logic                          r_v1, r_v2, r_v3;
    logic signed [DATA_WIDTH-1:0]  r_d1;
    logic [5:0]                    r_a1, r_a2, r_a3;
    logic [RECIP_WIDTH:0]          r_r1;
    logic signed [PW-1:0]          r_p2;
    logic [OUT_WIDTH-1:0]          r_o_data;
    logic                          r_o_sat;

    logic                          w_adv;
    logic [TSW-1:0]                w_ts;
    logic                          w_neg;
    logic [PW-1:0]                 w_abs;
    logic [XW-1:0]                 w_q;
    logic                          w_sat;
    logic [OUT_WIDTH-1:0]          w_qc;
    logic [OUT_WIDTH-1:0]          w_out;

    assign w_adv    = !r_v3 || out_ready;
    assign in_ready = w_adv;

    // Non-power-of-two table counts leave unused select codes; those fall back to table 0.
    assign w_ts = (int'(in_tsel) < NUM_TABLES) ? in_tsel : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_TABLES; t++)
                for (int e = 0; e < 64; e++)
                    r_tbl[t][e] <= RECIP_ONE;
        end else if (tbl_we && (int'(tbl_sel) < NUM_TABLES)) begin
            r_tbl[tbl_sel][tbl_addr] <= tbl_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_d1 <= '0;
            r_a1 <= '0;
            r_r1 <= '0;
            r_v2 <= 1'b0;
            r_p2 <= '0;
            r_a2 <= '0;
        end else if (w_adv) begin
            r_v1 <= in_valid;
            r_d1 <= in_data;
            r_a1 <= in_addr;
            r_r1 <= r_tbl[w_ts][in_addr];
            r_v2 <= r_v1;
            r_p2 <= r_d1 * $signed({1'b0, r_r1});
            r_a2 <= r_a1;
        end
    end

    // Work on the magnitude so rounding is symmetric and -0 cannot appear.
    assign w_neg = r_p2[PW-1];
    assign w_abs = w_neg ? $unsigned(-r_p2) : $unsigned(r_p2);
    assign w_q   = ({{(XW-PW){1'b0}}, w_abs} + HALF) >> RECIP_WIDTH;
    assign w_sat = w_q > MAXQ;
    assign w_qc  = w_sat ? MAXQ[OUT_WIDTH-1:0] : w_q[OUT_WIDTH-1:0];
    assign w_out = w_neg ? (~w_qc + 1'b1) : w_qc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3     <= 1'b0;
            r_o_data <= '0;
            r_a3     <= '0;
            r_o_sat  <= 1'b0;
        end else if (w_adv) begin
            r_v3     <= r_v2;
            r_o_data <= w_out;
            r_a3     <= r_a2;
            r_o_sat  <= r_v2 && w_sat;
        end
    end

    assign out_valid = r_v3;
    assign out_data  = r_o_data;
    assign out_addr  = r_a3;
    assign out_sat   = r_o_sat;
    assign out_eob   = r_v3 && (r_a3 == 6'd63);

endmodule

// File: tb/tb_quant_pipe.sv
// Bench for quant_pipe: a default instance and a truncating 8-bit-output instance share all inputs.
module tb_quant_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready, in_ready2;
    logic [9:0]  in_data;
    logic [5:0]  in_addr;
    logic [0:0]  in_tsel;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic [9:0]  out_data;
    logic [7:0]  out_data2;
    logic [5:0]  out_addr, out_addr2;
    logic        out_eob, out_eob2, out_sat, out_sat2;
    logic        tbl_we;
    logic [0:0]  tbl_sel;
    logic [5:0]  tbl_addr;
    logic [16:0] tbl_wdata;

    quant_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_addr(in_addr), .in_tsel(in_tsel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_eob(out_eob), .out_sat(out_sat),
        .tbl_we(tbl_we), .tbl_sel(tbl_sel), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata)
    );

    quant_pipe #(.OUT_WIDTH(8), .ROUND(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_addr(in_addr), .in_tsel(in_tsel),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_addr(out_addr2), .out_eob(out_eob2), .out_sat(out_sat2),
        .tbl_we(tbl_we), .tbl_sel(tbl_sel), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d1; bit s1; int d2; bit s2; int addr;
    } exp_t;

    exp_t sb[$];
    int   log1[$];
    int   log2[$];
    int   mtbl[2][64];
    int   checks = 0;
    int   errors = 0;
    int   n_eob  = 0;
    bit   rand_ready = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int quant(input int x, input int recip, input int rnd, input int ow, output bit sat);
        int p, m, q, mx;
        p   = x * recip;
        m   = (p < 0) ? -p : p;
        q   = (m + (rnd != 0 ? 32768 : 0)) / 65536;
        mx  = (1 << (ow - 1)) - 1;
        sat = q > mx;
        if (sat) q = mx;
        return (p < 0) ? -q : q;
    endfunction

    // Reference: scoreboard of expected outputs, table image, stall-stability tracking.
    bit   held = 0;
    int   h_d1, h_d2, h_a, h_s1;
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            held = 0;
            for (int t = 0; t < 2; t++)
                for (int e = 0; e < 64; e++)
                    mtbl[t][e] = 65536;
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_out_valid2", int'(out_valid2), 0);
        end else begin
            chk("in_ready", int'(in_ready), int'(!out_valid || out_ready));
            chk("vld_match", int'(out_valid2), int'(out_valid));
            if (!out_valid) chk("eob_idle", int'(out_eob), 0);
            if (held) begin
                chk("hold_data", int'($signed(out_data)), h_d1);
                chk("hold_data2", int'($signed(out_data2)), h_d2);
                chk("hold_addr", int'(out_addr), h_a);
                chk("hold_sat", int'(out_sat), h_s1);
            end
            held = 0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", int'($signed(out_data)), e.d1);
                    chk("out_sat", int'(out_sat), int'(e.s1));
                    chk("out_data2", int'($signed(out_data2)), e.d2);
                    chk("out_sat2", int'(out_sat2), int'(e.s2));
                    chk("out_addr", int'(out_addr), e.addr);
                    chk("out_eob", int'(out_eob), int'(e.addr == 63));
                    if (out_eob) n_eob++;
                    log1.push_back(e.d1);
                    log2.push_back(e.d2);
                end
            end else if (out_valid) begin
                held = 1;
                h_d1 = int'($signed(out_data));
                h_d2 = int'($signed(out_data2));
                h_a  = int'(out_addr);
                h_s1 = int'(out_sat);
            end
            if (in_valid && in_ready) begin
                exp_t e;
                int   r;
                r      = mtbl[in_tsel][in_addr];
                e.d1   = quant(int'($signed(in_data)), r, 1, 10, e.s1);
                e.d2   = quant(int'($signed(in_data)), r, 0, 8, e.s2);
                e.addr = int'(in_addr);
                sb.push_back(e);
            end
            if (tbl_we) mtbl[tbl_sel][tbl_addr] = int'(tbl_wdata);
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input int d, input int a, input int ts,
                        input bit we, input int wsel, input int waddr, input int wdat);
        logic acc;
        acc       = 1'b0;
        in_valid  = 1'b1;
        in_data   = d[9:0];
        in_addr   = a[5:0];
        in_tsel   = ts[0:0];
        tbl_we    = we;
        tbl_sel   = wsel[0:0];
        tbl_addr  = waddr[5:0];
        tbl_wdata = wdat[16:0];
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            tbl_we = 1'b0;
            if (acc) break;
        end
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic twrite(input int sel, input int addr, input int dat);
        tbl_we    = 1'b1;
        tbl_sel   = sel[0:0];
        tbl_addr  = addr[5:0];
        tbl_wdata = dat[16:0];
        @(posedge clk);
        #1;
        tbl_we = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((sb.size() != 0 || out_valid) && c < 500) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("drain_timeout", int'(c >= 500), 0);
    endtask

    initial begin
        bit s;
        int n0, quiet;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_addr = '0; in_tsel = '0;
        out_ready = 1'b1; tbl_we = 1'b0; tbl_sel = '0; tbl_addr = '0; tbl_wdata = '0;

        // Pin the model to hand-derived values.
        chk("model_pass", quant(100, 65536, 1, 10, s), 100);
        chk("model_q16_rnd", quant(-104, 4096, 1, 10, s), -7);
        chk("model_q16_trunc", quant(-104, 4096, 0, 10, s), -6);
        chk("model_small_neg", quant(-7, 4096, 1, 10, s), 0);
        chk("model_sat_pos", quant(300, 65536, 0, 8, s), 127);
        chk("model_sat_flag", int'(s), 1);
        chk("model_sat_neg", quant(-300, 65536, 0, 8, s), -127);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_out_sat", int'(out_sat), 0);
        chk("reset_out_eob", int'(out_eob), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Passthrough and exact 3-cycle latency.
        send(100, 5, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("latency_early_vld", int'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("latency_vld", int'(out_valid), 1);
        chk("pass_data", int'($signed(out_data)), 100);
        chk("pass_sat", int'(out_sat), 0);
        chk("pass_eob", int'(out_eob), 0);
        drain();

        // Q = 16 rounding vs truncation, and no negative zero.
        twrite(0, 0, 4096);
        send(-104, 0, 0, 0, 0, 0, 0);
        send(7, 0, 0, 0, 0, 0, 0);
        send(-7, 0, 0, 0, 0, 0, 0);
        drain();
        chk("q16_round", log1[log1.size()-3], -7);
        chk("q16_trunc", log2[log2.size()-3], -6);
        chk("q16_small_pos", log1[log1.size()-2], 0);
        chk("q16_small_neg", log1[log1.size()-1], 0);

        // Saturation on the 8-bit instance.
        send(300, 1, 0, 0, 0, 0, 0);
        send(-300, 2, 0, 0, 0, 0, 0);
        drain();
        chk("sat_pos", log2[log2.size()-2], 127);
        chk("sat_neg", log2[log2.size()-1], -127);
        chk("nosat_wide", log1[log1.size()-1], -300);

        // Write and lookup of the same entry in one cycle: old value wins.
        send(80, 3, 1, 1, 1, 3, 8192);
        send(80, 3, 1, 0, 0, 0, 0);
        drain();
        chk("coll_old", log1[log1.size()-2], 80);
        chk("coll_new", log1[log1.size()-1], 10);

        // Random stream with random stalls and background table updates.
        n0 = log1.size();
        rand_ready = 1;
        for (int i = 0; i < 64; i++) begin
            int d, ts;
            d  = int'($urandom_range(0, 1023)) - 512;
            ts = int'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 3) == 0)
                send(d, i, ts, 1, int'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                     65536 / int'($urandom_range(1, 255)));
            else
                send(d, i, ts, 0, 0, 0, 0);
        end
        drain();
        rand_ready = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        chk("stream_count", log1.size() - n0, 64);
        chk("eob_count", n_eob, 1);

        // Reset with three samples in flight.
        send(11, 0, 0, 0, 0, 0, 0);
        send(22, 1, 0, 0, 0, 0, 0);
        send(33, 2, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_drop_vld", int'(out_valid), 0);
        n0 = log1.size();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        quiet = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid) quiet++;
        end
        chk("post_rst_quiet", quiet, 0);
        chk("post_rst_no_out", log1.size() - n0, 0);
        send(100, 3, 1, 0, 0, 0, 0);
        send(-104, 0, 0, 0, 0, 0, 0);
        drain();
        chk("post_rst_tbl1", log1[log1.size()-2], 100);
        chk("post_rst_tbl0", log1[log1.size()-1], -104);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
